// File: rtl/pkt_chan_sched.sv
// pkt_chan_sched: round-robin channel scheduler with former/MAC handshake, inter-packet gap, overflow flush and TX watchdog
module pkt_chan_sched #(
  parameter int N_CH      = 2,
  parameter int LVL_W     = 9,
  parameter int PKT_WORDS = 360,
  parameter int GAP_CYC   = 50,
  parameter int WD_CYC    = 20000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*LVL_W-1:0]  ch_level,
  input  logic [N_CH-1:0]        ch_full,
  input  logic [N_CH-1:0]        ch_en,
  output logic                   grant_valid,
  output logic [7:0]             grant_ch,
  input  logic                   grant_ready,
  input  logic                   pkt_done,
  input  logic                   end_tx,
  output logic                   abort,
  output logic [N_CH-1:0]        flush,
  output logic                   busy,
  output logic [15:0]            ovf_cnt,
  output logic                   wd_err
);
  localparam int PTR_W = (N_CH > 2) ? 2 : 1;
  localparam int CNT_W = $clog2(WD_CYC + GAP_CYC + 2);
  typedef enum logic [2:0] {IDLE, GRANT, BUILD, TX, GAP} state_t;
  state_t           r_state;
  logic [PTR_W-1:0] r_rr, r_gch, w_pick, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [N_CH-1:0]  r_fq, r_fqq, w_rise, w_elig;
  logic [2:0]       w_pop;
  logic [16:0]      w_sum;
  logic             w_abort;
  int               w_j;
  always_comb begin
    w_pick = r_rr;
    w_j = 0;
    for (int i = 0; i < N_CH; i++)
      w_elig[i] = ch_en[i] & ~ch_full[i] & (32'(ch_level[i*LVL_W +: LVL_W]) >= 32'(PKT_WORDS));
    // descending scan so the smallest offset from r_rr wins
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_j = int'(r_rr) + k;
      w_j = (w_j >= N_CH) ? w_j - N_CH : w_j;
      if (w_elig[w_j]) w_pick = PTR_W'(w_j);
    end
  end
  assign w_next   = (r_gch == PTR_W'(N_CH - 1)) ? '0 : r_gch + 1'b1;
  assign w_rise   = r_fq & ~r_fqq;
  assign w_abort  = (r_state == GRANT || r_state == BUILD) && w_rise[r_gch];
  assign w_pop    = 3'($countones(w_rise));
  assign w_sum    = {1'b0, ovf_cnt} + {14'b0, w_pop};
  assign busy     = r_state != IDLE;
  assign grant_ch = 8'(r_gch);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr        <= '0;
      r_gch       <= '0;
      r_cnt       <= '0;
      r_fq        <= '0;
      r_fqq       <= '0;
      grant_valid <= 1'b0;
      abort       <= 1'b0;
      flush       <= '0;
      ovf_cnt     <= '0;
      wd_err      <= 1'b0;
    end else begin
      r_fq    <= ch_full;
      r_fqq   <= r_fq;
      flush   <= w_rise;
      abort   <= w_abort;
      ovf_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
      if (w_abort) begin
        grant_valid <= 1'b0;
        r_rr        <= w_next;
        r_cnt       <= '0;
        r_state     <= GAP;
      end else begin
        case (r_state)
          IDLE: if (|w_elig) begin
            r_gch       <= w_pick;
            grant_valid <= 1'b1;
            r_state     <= GRANT;
          end
          GRANT: if (grant_ready) begin
            grant_valid <= 1'b0;
            r_rr        <= w_next;
            r_state     <= BUILD;
          end
          BUILD: if (pkt_done) begin
            r_cnt   <= '0;
            r_state <= TX;
          end
          TX: if (end_tx || r_cnt == CNT_W'(WD_CYC - 1)) begin
            wd_err  <= wd_err | ~end_tx;
            r_cnt   <= '0;
            r_state <= GAP;
          end else r_cnt <= r_cnt + 1'b1;
          GAP: if (r_cnt == CNT_W'(GAP_CYC)) r_state <= IDLE;
            else r_cnt <= r_cnt + 1'b1;
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pkt_chan_sched.sv
// tb_pkt_chan_sched: directed checks of arbitration, handshake, gap, abort, watchdog, reset and overflow saturation
module tb_pkt_chan_sched;
  logic        clk = 0, rst = 1;
  logic [17:0] ch_level = '0;
  logic [1:0]  ch_full = '0, ch_en = '0, flush;
  logic        grant_valid, grant_ready = 0, pkt_done = 0, end_tx = 0, abort, busy, wd_err;
  logic [7:0]  grant_ch;
  logic [15:0] ovf_cnt;
  int          n_err = 0, n_chk = 0;

  pkt_chan_sched #(.N_CH(2), .LVL_W(9), .PKT_WORDS(360), .GAP_CYC(50), .WD_CYC(100)) dut (
    .clk(clk), .rst(rst), .ch_level(ch_level), .ch_full(ch_full), .ch_en(ch_en),
    .grant_valid(grant_valid), .grant_ch(grant_ch), .grant_ready(grant_ready),
    .pkt_done(pkt_done), .end_tx(end_tx), .abort(abort), .flush(flush),
    .busy(busy), .ovf_cnt(ovf_cnt), .wd_err(wd_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(input int c0, input int exp_gap);
    int c = c0;
    while (!grant_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    chk("gap_len", 32'(c), 32'(exp_gap));
  endtask

  // expects grant_valid high now and grant_ready=1; exp_gap==0 disables channels after the packet
  task automatic run_pkt(input int exp_ch, input int exp_gap);
    chk("pkt_gv", 32'(grant_valid), 1);
    chk("pkt_ch", 32'(grant_ch), 32'(exp_ch));
    @(negedge clk);
    chk("hs_gv", 32'(grant_valid), 0);
    chk("hs_busy", 32'(busy), 1);
    pkt_done = 1;
    @(negedge clk);
    pkt_done = 0;
    end_tx = 1;
    @(negedge clk);
    end_tx = 0;
    if (exp_gap == 0) begin
      ch_en = 2'b00;
      repeat (60) @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_gv", 32'(grant_valid), 0);
    end else wait_grant(0, exp_gap);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_gv", 32'(grant_valid), 0);
    chk("rst_gch", 32'(grant_ch), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf", 32'(ovf_cnt), 0);
    chk("rst_wd", 32'(wd_err), 0);
    rst = 0;
    // alternating grants
    ch_level = {9'd400, 9'd400};
    ch_en = 2'b11;
    grant_ready = 1;
    @(negedge clk);
    run_pkt(0, 52);
    run_pkt(1, 52);
    run_pkt(0, 52);
    run_pkt(1, 0);
    // threshold and round-robin with level raised during TX
    ch_level = {9'd360, 9'd359};
    ch_en = 2'b11;
    @(negedge clk);
    chk("thr_gv", 32'(grant_valid), 1);
    chk("thr_ch", 32'(grant_ch), 1);
    @(negedge clk);
    pkt_done = 1;
    @(negedge clk);
    pkt_done = 0;
    ch_level = {9'd360, 9'd360};
    end_tx = 1;
    @(negedge clk);
    end_tx = 0;
    wait_grant(0, 52);
    run_pkt(0, 0);
    // granted-channel overflow in BUILD
    ch_en = 2'b11;
    @(negedge clk);
    chk("ab_ch", 32'(grant_ch), 1);
    @(negedge clk);
    chk("ab_build", 32'(busy), 1);
    ch_full = 2'b10;
    @(negedge clk);
    chk("ab_early", 32'(abort), 0);
    chk("ab_fl_early", 32'(flush), 0);
    @(negedge clk);
    chk("ab_pulse", 32'(abort), 1);
    chk("ab_flush", 32'(flush), 2);
    chk("ab_ovf", 32'(ovf_cnt), 1);
    chk("ab_gv", 32'(grant_valid), 0);
    chk("ab_busy", 32'(busy), 1);
    grant_ready = 0;
    pkt_done = 1;
    @(negedge clk);
    pkt_done = 0;
    ch_full = 2'b00;
    chk("ab_end", 32'(abort), 0);
    chk("ab_fl_end", 32'(flush), 0);
    wait_grant(1, 52);
    chk("ab_next_ch", 32'(grant_ch), 0);
    // grant held while grant_ready low
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("hold_gv", 32'(grant_valid), 1);
      chk("hold_ch", 32'(grant_ch), 0);
    end
    grant_ready = 1;
    @(negedge clk);
    chk("hold_hs", 32'(grant_valid), 0);
    rst = 1;
    @(negedge clk);
    chk("mrst_gv", 32'(grant_valid), 0);
    chk("mrst_gch", 32'(grant_ch), 0);
    chk("mrst_abort", 32'(abort), 0);
    chk("mrst_flush", 32'(flush), 0);
    chk("mrst_busy", 32'(busy), 0);
    chk("mrst_ovf", 32'(ovf_cnt), 0);
    chk("mrst_wd", 32'(wd_err), 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_gv", 32'(grant_valid), 1);
    chk("post_rst_ch", 32'(grant_ch), 0);
    // watchdog, with a stray end_tx in BUILD
    @(negedge clk);
    end_tx = 1;
    @(negedge clk);
    end_tx = 0;
    chk("wd_build", 32'(busy), 1);
    pkt_done = 1;
    @(negedge clk);
    pkt_done = 0;
    repeat (99) @(negedge clk);
    chk("wd_before", 32'(wd_err), 0);
    @(negedge clk);
    chk("wd_set", 32'(wd_err), 1);
    ch_en = 2'b00;
    repeat (50) @(negedge clk);
    chk("wd_gap", 32'(busy), 1);
    @(negedge clk);
    chk("wd_idle", 32'(busy), 0);
    repeat (10) @(negedge clk);
    chk("wd_sticky", 32'(wd_err), 1);
    // overflow counting and saturation
    ch_full = 2'b11;
    @(negedge clk);
    chk("ovf_early", 32'(flush), 0);
    @(negedge clk);
    chk("ovf_both", 32'(flush), 3);
    chk("ovf_two", 32'(ovf_cnt), 2);
    ch_full = 2'b00;
    @(negedge clk);
    chk("ovf_clr", 32'(flush), 0);
    ch_full = 2'b01;
    @(negedge clk);
    ch_full = 2'b00;
    @(negedge clk);
    chk("ovf_one", 32'(flush), 1);
    chk("ovf_three", 32'(ovf_cnt), 3);
    for (int i = 0; i < 33000; i++) begin
      ch_full = 2'b11;
      @(negedge clk);
      ch_full = 2'b00;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("ovf_sat", 32'(ovf_cnt), 32'hFFFF);
    chk("ovf_fsm", 32'(busy), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
